// File: rtl/inst_rom_port.sv
// Fetch-side instruction memory: one-cycle registered read from a word array,
// with alignment/range flagging, a fetch counter and an independent load port.
module inst_rom_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_err,
  input  logic              load_en,
  input  logic [IDX_W:0]    load_idx,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  output logic [31:0]       fetch_cnt
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              load_err_q, load_err_d;
  logic [31:0]       fetch_cnt_q, fetch_cnt_d;

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  fetch_idx;
  logic              in_range, aligned, fetch_good, load_ok;

  // Range check uses the full shifted address so upper bits cannot alias into the array.
  assign word_addr  = addr >> 2;
  assign in_range   = word_addr < ADDR_W'(DEPTH);
  assign aligned    = (addr[1:0] == 2'b00);
  assign fetch_idx  = addr[IDX_W+1:2];
  assign fetch_good = ce && in_range && aligned;
  assign load_ok    = load_idx < (IDX_W+1)'(DEPTH);

  always_comb begin
    inst_d       = '0;
    inst_valid_d = ce;
    addr_err_d   = ce && !fetch_good;
    load_err_d   = load_en && !load_ok;
    fetch_cnt_d  = fetch_cnt_q;
    if (fetch_good) begin
      inst_d      = mem_q[fetch_idx];
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      load_err_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
      load_err_q   <= load_err_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  // Array is never cleared; the read above sees the pre-write word on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (!rst && load_en && load_ok) begin
      mem_q[load_idx[IDX_W-1:0]] <= load_data;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;
  assign load_err   = load_err_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_inst_rom_port.sv
// Scoreboarded bench for inst_rom_port: the driver queues each expected fetch
// response with its due cycle, a negedge monitor pops and compares.
module tb_inst_rom_port;

  logic        clk = 1'b0;
  logic        rst, ce, load_en;
  logic [31:0] addr, load_data;
  logic [10:0] load_idx;
  logic [31:0] inst, fetch_cnt;
  logic        inst_valid, addr_err, load_err;

  typedef struct {
    int          due;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  inst_rom_port #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .IDX_W(10)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr),
    .inst(inst), .inst_valid(inst_valid), .addr_err(addr_err),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .load_err(load_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: apply inputs, optionally queue the response due after the coming edge.
  task automatic drive(input logic r, input logic c, input logic [31:0] a,
                       input logic le, input logic [10:0] li, input logic [31:0] ld,
                       input logic push, input logic [31:0] e_inst, input logic e_err);
    exp_t e;
    rst = r; ce = c; addr = a; load_en = le; load_idx = li; load_data = ld;
    if (push) begin
      e.due = cyc + 1; e.inst = e_inst; e.err = e_err;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 0, 11'd0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] e_inst, input logic e_err);
    drive(0, 1, a, 0, 11'd0, 32'h0, 1, e_inst, e_err);
  endtask

  task automatic load(input logic [10:0] li, input logic [31:0] ld);
    drive(0, 0, 32'h0, 1, li, ld, 0, 32'h0, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_valid", 32'(inst_valid), 32'd1);
        chk("resp_inst", inst, e.inst);
        chk("resp_addr_err", 32'(addr_err), 32'(e.err));
      end else begin
        chk("idle_valid", 32'(inst_valid), 32'd0);
        chk("idle_inst", inst, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; ce = 0; addr = '0; load_en = 0; load_idx = '0; load_data = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    drive(1, 0, 32'h0, 0, 11'd0, 32'h0, 0, 32'h0, 0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);

    load(11'd0, 32'h34010001);
    load(11'd1, 32'h34020002);
    load(11'd2, 32'h34030003);
    load(11'd3, 32'h34040004);
    load(11'd5, 32'hAAAA0000);
    load(11'd6, 32'h66666666);

    // Reset edge with a fetch and a load pending: both must be suppressed.
    drive(1, 1, 32'h0, 1, 11'd6, 32'hDEAD0006, 0, 32'h0, 0);
    chk("rst_prio_cnt", fetch_cnt, 32'd0);
    idle(1);

    fetch(32'h0, 32'h34010001, 0);
    fetch(32'h4, 32'h34020002, 0);
    fetch(32'h8, 32'h34030003, 0);
    fetch(32'hC, 32'h34040004, 0);
    chk("startup_cnt", fetch_cnt, 32'd4);

    fetch(32'h00000006, 32'h0, 1);
    chk("misalign_cnt", fetch_cnt, 32'd4);
    fetch(32'h00001000, 32'h0, 1);
    fetch(32'h80000000, 32'h0, 1);
    chk("range_cnt", fetch_cnt, 32'd4);

    fetch(32'h18, 32'h66666666, 0);
    chk("rst_no_write_cnt", fetch_cnt, 32'd5);

    drive(0, 1, 32'h14, 1, 11'd5, 32'h5555FFFF, 1, 32'hAAAA0000, 0);
    chk("collide_load_err", 32'(load_err), 32'd0);
    chk("collide_cnt", fetch_cnt, 32'd6);
    fetch(32'h14, 32'h5555FFFF, 0);
    chk("refetch_cnt", fetch_cnt, 32'd7);

    load(11'd1024, 32'hDEADBEEF);
    chk("load_err_set", 32'(load_err), 32'd1);
    fetch(32'h0, 32'h34010001, 0);
    chk("load_err_clear", 32'(load_err), 32'd0);
    chk("after_loaderr_cnt", fetch_cnt, 32'd8);

    idle(2);
    chk("ce_drop_cnt", fetch_cnt, 32'd8);

    fetch(32'h4, 32'h34020002, 0);
    drive(1, 1, 32'h8, 0, 11'd0, 32'h0, 0, 32'h0, 0);
    chk("midrst_cnt", fetch_cnt, 32'd0);
    chk("midrst_load_err", 32'(load_err), 32'd0);
    idle(1);
    fetch(32'h0, 32'h34010001, 0);
    chk("post_rst_cnt", fetch_cnt, 32'd1);
    idle(2);

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_rom_port.md
# inst_rom_port

Instruction-memory responder on the fetch side of the pipeline. Each cycle the program counter drives a byte address and chip enable, and this block returns the addressed 32-bit instruction word one clock later from a synchronous word array. It flags misaligned or out-of-range fetches and counts successful fetches. A side load port lets the boot loader or testbench write program words into the array.

## Interface
- DATA_W, 32, instruction word width
- ADDR_W, 32, fetch byte-address width
- DEPTH, 1024, array depth in words (power of two)
- IDX_W, 10, log2(DEPTH), word-index width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ce  in  1  fetch chip enable, 1 = enabled
- addr  in  ADDR_W  fetch byte address
- inst  out  DATA_W  registered instruction word
- inst_valid  out  1  inst/addr_err hold the response to the previous cycle's fetch
- addr_err  out  1  previous fetch was misaligned or out of range
- load_en  in  1  load-port write strobe
- load_idx  in  IDX_W+1  load word index (MSB allows out-of-range detection)
- load_data  in  DATA_W  load word
- load_err  out  1  registered pulse: previous load index out of range, write dropped
- fetch_cnt  out  32  count of successful fetches

## Operation
- Word index = addr[IDX_W+1:2].
- Range check: addr >> 2 must be < DEPTH, using all upper bits, not only the index field.
- Misaligned: addr[1:0] != 0.
- Array contents are not cleared by rst; only the output registers and the counter reset.
- Each rising edge with rst=0 and ce=1:
  - Fetch good: inst <= mem[idx], inst_valid <= 1, addr_err <= 0, fetch_cnt += 1.
  - Fetch bad (misaligned or out of range): inst <= 0 (NOP), inst_valid <= 1, addr_err <= 1, counter unchanged.
- Each edge with rst=0 and ce=0: inst <= 0, inst_valid <= 0, addr_err <= 0. The array is not read.
- Load port, each edge with rst=0 and load_en=1:
  - load_idx < DEPTH: mem[load_idx] <= load_data, load_err <= 0.
  - Otherwise: no write, load_err <= 1.
  - load_en=0: load_err <= 0.
- The load port operates independently of ce.
- Fetch and load to the same word in the same cycle: the fetch returns the OLD word (read-before-write). The new word is visible from the next fetch.
- fetch_cnt wraps from 0xFFFF_FFFF to 0 with no flag.
- rst has priority over everything: no array write and no counter increment during a reset cycle.

## Timing
- Reset values: inst=0, inst_valid=0, addr_err=0, load_err=0, fetch_cnt=0.
- Read latency is 1 cycle: addr/ce sampled at edge k produce inst/inst_valid/addr_err valid after edge k, for the whole cycle k..k+1.
- Fetch throughput is one word per cycle with no stalls and no backpressure.
- Load write latency is 1 edge; load_err is valid for one cycle after the offending edge.
- The PC drives ce=1 one cycle after rst deasserts, with addr=0 on that first enabled cycle. Therefore:
  - First valid response is mem[0], appearing two edges after rst falls.
  - The address stream then advances by 4 per cycle.
- rst asserted mid-stream: the response registered at that edge is discarded. inst_valid=0 and inst=0 after the reset edge. Array contents persist.

## Test plan
- Reset/startup: preload mem[0..3] = 0x34010001, 0x34020002, 0x34030003, 0x34040004 via the load port. Release rst; the PC model drives ce=1 with addr 0,4,8,12 on consecutive cycles.
  - Required: inst_valid stays 0 until the first fetch's response.
  - Then inst = the four words on consecutive cycles; fetch_cnt ends at 4; addr_err stays 0.
- Misaligned fetch: ce=1, addr=0x00000006 -> next cycle inst=0, inst_valid=1, addr_err=1, fetch_cnt unchanged.
- Out-of-range fetch: DEPTH=1024, addr=0x00001000 -> inst=0, addr_err=1.
  - Also addr=0x80000000 (upper bits set, index field zero) -> addr_err=1, not mem[0].
- Same-cycle fetch/load collision: mem[5]=0xAAAA0000; in one cycle fetch addr=0x14 with load_en=1, load_idx=5, load_data=0x5555FFFF.
  - Required: response 0xAAAA0000.
  - Refetch of 0x14 returns 0x5555FFFF.
- Load error: load_en=1, load_idx=1024 -> load_err=1 for exactly one cycle; a subsequent fetch of addr 0 returns its prior contents unchanged.
- ce drop and mid-run reset: ce=0 for 2 cycles -> inst_valid=0, inst=0.
  - Assert rst for one edge mid-stream -> all outputs return to reset values, fetch_cnt=0.
  - After rst, refetch of addr 0 returns the preloaded word (array retained).
